// File: rtl/texture_filter_pkg.sv
// Shared mode encodings and lerp width helpers for the texture filter pipeline.
package texture_filter_pkg;

   localparam logic [1:0] TF_MODE_NEAREST       = 2'd0;
   localparam logic [1:0] TF_MODE_BILINEAR      = 2'd1;
   localparam logic [1:0] TF_MODE_NEAREST_ROUND = 2'd2;

   // a*(one-f) + b*f + one/2 stays below 2^(cw+spw), so one extra bit is ample headroom
   function automatic int lerp_acc_w(input int cw, input int spw);
      return cw + spw + 1;
   endfunction

   function automatic int lerp_half_shift(input int spw);
      return spw - 1;
   endfunction

endpackage

// File: rtl/texture_lerp.sv
// Single-channel combinational linear interpolation with round-half-up.
module texture_lerp
   import texture_filter_pkg::*;
#(
   parameter int CHANNEL_WIDTH   = 8,
   parameter int SUB_PIXEL_WIDTH = 8
) (
   input  logic [CHANNEL_WIDTH-1:0]   a,
   input  logic [CHANNEL_WIDTH-1:0]   b,
   input  logic [SUB_PIXEL_WIDTH-1:0] f,
   output logic [CHANNEL_WIDTH-1:0]   result
);

   localparam int ACC_W = lerp_acc_w(CHANNEL_WIDTH, SUB_PIXEL_WIDTH);
   localparam logic [ACC_W-1:0] ONE  = ACC_W'(1) << SUB_PIXEL_WIDTH;
   localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << lerp_half_shift(SUB_PIXEL_WIDTH);

   function automatic logic [CHANNEL_WIDTH-1:0] round_shift(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0] r;
      r = (acc + HALF) >> SUB_PIXEL_WIDTH;
      return r[CHANNEL_WIDTH-1:0];
   endfunction

   logic [ACC_W-1:0] acc;

   always_comb begin
      acc    = ACC_W'(a) * (ONE - ACC_W'(f)) + ACC_W'(b) * ACC_W'(f);
      result = round_shift(acc);
   end

endmodule

// File: rtl/texture_filter_pipe.sv
// Four-stage elastic 2x2 texel filter (nearest / bilinear / nearest-rounded).
// Mode 2 rounded selection is built only when RIX_TEXFILTER_NEAREST_ROUNDED_EN is defined.
module texture_filter_pipe
   import texture_filter_pkg::*;
#(
   parameter  int USER_WIDTH      = 1,
   parameter  int CHANNELS        = 4,
   parameter  int CHANNEL_WIDTH   = 8,
   parameter  int SUB_PIXEL_WIDTH = 8,
   localparam int PIXEL_WIDTH     = CHANNELS * CHANNEL_WIDTH
) (
   input  logic                   aclk,
   input  logic                   resetn,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [USER_WIDTH-1:0]  s_user,
   input  logic [1:0]             s_mode,
   input  logic [PIXEL_WIDTH-1:0] s_texel00,
   input  logic [PIXEL_WIDTH-1:0] s_texel01,
   input  logic [PIXEL_WIDTH-1:0] s_texel10,
   input  logic [PIXEL_WIDTH-1:0] s_texel11,
   input  logic [15:0]            s_texelSubCoordS,
   input  logic [15:0]            s_texelSubCoordT,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [USER_WIDTH-1:0]  m_user,
   output logic [PIXEL_WIDTH-1:0] m_texel
);

   localparam int CW  = CHANNEL_WIDTH;
   localparam int SPW = SUB_PIXEL_WIDTH;

   logic vld_p1, vld_p2, vld_p3, vld_p4;
   logic rdy_p1, rdy_p2, rdy_p3, rdy_p4;

   assign rdy_p4  = !vld_p4 || m_ready;
   assign rdy_p3  = !vld_p3 || rdy_p4;
   assign rdy_p2  = !vld_p2 || rdy_p3;
   assign rdy_p1  = !vld_p1 || rdy_p2;
   assign s_ready = rdy_p1;
   assign m_valid = vld_p4;

   // Only the top SPW fraction bits feed the datapath
   logic unused_coord_bits;
   assign unused_coord_bits = ^{s_texelSubCoordS, s_texelSubCoordT};

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         vld_p4 <= 1'b0;
      end else begin
         if (rdy_p1) vld_p1 <= s_valid;
         if (rdy_p2) vld_p2 <= vld_p1;
         if (rdy_p3) vld_p3 <= vld_p2;
         if (rdy_p4) vld_p4 <= vld_p3;
      end
   end

   // P1: input register
   logic [USER_WIDTH-1:0]  user_p1;
   logic [1:0]             mode_p1;
   logic [PIXEL_WIDTH-1:0] t00_p1, t01_p1, t10_p1, t11_p1;
   logic [SPW-1:0]         fs_p1, ft_p1;

   always_ff @(posedge aclk) begin
      if (rdy_p1 && s_valid) begin
         user_p1 <= s_user;
         mode_p1 <= s_mode;
         t00_p1  <= s_texel00;
         t01_p1  <= s_texel01;
         t10_p1  <= s_texel10;
         t11_p1  <= s_texel11;
         fs_p1   <= s_texelSubCoordS[15 -: SPW];
         ft_p1   <= s_texelSubCoordT[15 -: SPW];
      end
   end

   // P2: horizontal lerps and nearest selection
   logic [PIXEL_WIDTH-1:0] h0_comb, h1_comb, v_comb, near_comb;
   logic [PIXEL_WIDTH-1:0] h0_p2, h1_p2, near_p2;
   logic [SPW-1:0]         ft_p2;
   logic [USER_WIDTH-1:0]  user_p2;
   logic                   bil_p2;

   always_comb begin
      near_comb = t00_p1;
`ifdef RIX_TEXFILTER_NEAREST_ROUNDED_EN
      // Top fraction bit of each coordinate picks the nearer texel column/row
      if (mode_p1 == TF_MODE_NEAREST_ROUND) begin
         case ({ft_p1[SPW-1], fs_p1[SPW-1]})
            2'b00:   near_comb = t00_p1;
            2'b01:   near_comb = t01_p1;
            2'b10:   near_comb = t10_p1;
            default: near_comb = t11_p1;
         endcase
      end
`endif
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      texture_lerp #(.CHANNEL_WIDTH(CW), .SUB_PIXEL_WIDTH(SPW)) u_h0 (
         .a(t00_p1[c*CW +: CW]), .b(t01_p1[c*CW +: CW]), .f(fs_p1), .result(h0_comb[c*CW +: CW]));
      texture_lerp #(.CHANNEL_WIDTH(CW), .SUB_PIXEL_WIDTH(SPW)) u_h1 (
         .a(t10_p1[c*CW +: CW]), .b(t11_p1[c*CW +: CW]), .f(fs_p1), .result(h1_comb[c*CW +: CW]));
      texture_lerp #(.CHANNEL_WIDTH(CW), .SUB_PIXEL_WIDTH(SPW)) u_v (
         .a(h0_p2[c*CW +: CW]), .b(h1_p2[c*CW +: CW]), .f(ft_p2), .result(v_comb[c*CW +: CW]));
   end

   always_ff @(posedge aclk) begin
      if (rdy_p2 && vld_p1) begin
         h0_p2   <= h0_comb;
         h1_p2   <= h1_comb;
         near_p2 <= near_comb;
         ft_p2   <= ft_p1;
         user_p2 <= user_p1;
         bil_p2  <= (mode_p1 == TF_MODE_BILINEAR);
      end
   end

   // P3: vertical lerp
   logic [PIXEL_WIDTH-1:0] v_p3, near_p3;
   logic [USER_WIDTH-1:0]  user_p3;
   logic                   bil_p3;

   always_ff @(posedge aclk) begin
      if (rdy_p3 && vld_p2) begin
         v_p3    <= v_comb;
         near_p3 <= near_p2;
         user_p3 <= user_p2;
         bil_p3  <= bil_p2;
      end
   end

   // P4: mode mux / output register (outputs are defined as zero out of reset)
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         m_texel <= '0;
         m_user  <= '0;
      end else if (rdy_p4 && vld_p3) begin
         m_texel <= bil_p3 ? v_p3 : near_p3;
         m_user  <= user_p3;
      end
   end

endmodule

// File: tb/tb_texture_filter_pipe.sv
// Randomized scoreboard bench for texture_filter_pipe with a behavioural filter model.
module tb_texture_filter_pipe;

   localparam int UW  = 4;
   localparam int CH  = 4;
   localparam int CW  = 8;
   localparam int SPW = 8;
   localparam int PW  = CH * CW;
`ifdef RIX_TEXFILTER_NEAREST_ROUNDED_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          resetn;
   logic          s_valid, s_ready, m_valid, m_ready;
   logic [UW-1:0] s_user, m_user;
   logic [1:0]    s_mode;
   logic [PW-1:0] s_texel00, s_texel01, s_texel10, s_texel11, m_texel;
   logic [15:0]   s_s, s_t;

   always #5 aclk = ~aclk;

   texture_filter_pipe #(.USER_WIDTH(UW), .CHANNELS(CH), .CHANNEL_WIDTH(CW), .SUB_PIXEL_WIDTH(SPW)) dut (
      .aclk(aclk), .resetn(resetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_user(s_user), .s_mode(s_mode),
      .s_texel00(s_texel00), .s_texel01(s_texel01), .s_texel10(s_texel10), .s_texel11(s_texel11),
      .s_texelSubCoordS(s_s), .s_texelSubCoordT(s_t),
      .m_valid(m_valid), .m_ready(m_ready), .m_user(m_user), .m_texel(m_texel));

   typedef struct {
      logic [UW-1:0] user;
      logic [PW-1:0] texel;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   int   rdy_phase = 0;

   function automatic longint lerp_ref(input longint a, input longint b, input longint f);
      longint one;
      one = longint'(1) << SPW;
      return (a * (one - f) + b * f + one / 2) >> SPW;
   endfunction

   function automatic logic [PW-1:0] model(input logic [1:0] mode,
                                           input logic [PW-1:0] q00, input logic [PW-1:0] q01,
                                           input logic [PW-1:0] q10, input logic [PW-1:0] q11,
                                           input logic [15:0] s, input logic [15:0] t);
      logic [PW-1:0] r;
      longint fs, ft, h0, h1;
      fs = longint'(s) >> (16 - SPW);
      ft = longint'(t) >> (16 - SPW);
      r  = q00;
      if (mode == 2'd1) begin
         for (int c = 0; c < CH; c++) begin
            h0 = lerp_ref(longint'(q00[c*CW +: CW]), longint'(q01[c*CW +: CW]), fs);
            h1 = lerp_ref(longint'(q10[c*CW +: CW]), longint'(q11[c*CW +: CW]), fs);
            r[c*CW +: CW] = CW'(lerp_ref(h0, h1, ft));
         end
      end else if (mode == 2'd2 && ROUND_EN) begin
         case ({t[15], s[15]})
            2'b00:   r = q00;
            2'b01:   r = q01;
            2'b10:   r = q10;
            default: r = q11;
         endcase
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic send(input logic [1:0] mode, input logic [UW-1:0] user,
                       input logic [PW-1:0] q00, input logic [PW-1:0] q01,
                       input logic [PW-1:0] q10, input logic [PW-1:0] q11,
                       input logic [15:0] s, input logic [15:0] t);
      int  waited = 0;
      bit  done = 0;
      @(negedge aclk);
      s_mode = mode; s_user = user;
      s_texel00 = q00; s_texel01 = q01; s_texel10 = q10; s_texel11 = q11;
      s_s = s; s_t = t;
      s_valid = 1'b1;
      while (!done) begin
         #2;
         if (s_ready) begin
            @(posedge aclk);
            sb.push_back('{user, model(mode, q00, q01, q10, q11, s, t)});
            done = 1;
         end else begin
            waited++;
            if (waited > 200) begin
               checks++; errors++;
               $display("FAIL send_timeout got s_ready=0 want 1 within 200 cycles");
               s_valid = 1'b0;
               done = 1;
            end else begin
               @(negedge aclk);
            end
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      @(negedge aclk);
      s_valid = 1'b0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge aclk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      m_ready = 1'b1;
      forever begin
         @(negedge aclk);
         case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
               m_ready = (rdy_phase == 0 || rdy_phase == 3);
               rdy_phase = (rdy_phase + 1) % 4;
            end
            2: m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: samples mid-cycle after m_ready has settled; pops when a transfer is due at the next edge
   initial begin
      bit            stalled = 0;
      logic [PW-1:0] held_t;
      logic [UW-1:0] held_u;
      exp_t          e;
      forever begin
         @(negedge aclk);
         #3;
         if (!resetn) begin
            stalled = 0;
         end else begin
            if (stalled) begin
               check("hold_valid", PW'(m_valid), PW'(1));
               check("hold_texel", m_texel, held_t);
               check("hold_user", PW'(m_user), PW'(held_u));
            end
            check("s_ready", PW'(s_ready), PW'((sb.size() < 4) || m_ready));
            if (m_valid && m_ready) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_output got texel %h user %h want none", m_texel, m_user);
               end else begin
                  e = sb.pop_front();
                  check("out_texel", m_texel, e.texel);
                  check("out_user", PW'(m_user), PW'(e.user));
               end
            end
            stalled = m_valid && !m_ready;
            held_t  = m_texel;
            held_u  = m_user;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] q [4];
      resetn = 1'b0;
      s_valid = 1'b0; s_mode = '0; s_user = '0;
      s_texel00 = '0; s_texel01 = '0; s_texel10 = '0; s_texel11 = '0;
      s_s = '0; s_t = '0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_m_valid", PW'(m_valid), PW'(0));
      check("rst_m_texel", m_texel, '0);
      check("rst_m_user", PW'(m_user), PW'(0));
      @(negedge aclk);
      resetn = 1'b1;
      #1;
      check("rst_s_ready", PW'(s_ready), PW'(1));

      // Exact 4-edge latency on a half-way bilinear sample
      send(2'd1, 4'h5, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 16'h8000, 16'h0000);
      @(negedge aclk);
      s_valid = 1'b0;
      @(posedge aclk);
      @(posedge aclk);
      #1;
      check("lat_early_valid", PW'(m_valid), PW'(0));
      @(posedge aclk);
      #1;
      check("lat_valid", PW'(m_valid), PW'(1));
      check("lat_texel", m_texel, 32'h8080_8080);
      drain();

      // Constant quad must pass through bilinear unchanged
      for (int i = 0; i < 20; i++)
         send(2'd1, UW'(i), 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
              16'($urandom), 16'($urandom));
      drain();

      // Mode sweep
      for (int m = 0; m < 4; m++)
         send(2'(m), UW'(m), 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
              16'hC000, 16'h4000);
      drain();

      // Boundary fractions 0 and max plus fully random traffic under random backpressure
      rdy_mode = 3;
      for (int i = 0; i < 60; i++) begin
         for (int k = 0; k < 4; k++) q[k] = PW'($urandom);
         send(2'($urandom_range(0, 3)), UW'($urandom),
              q[0], q[1], q[2], q[3],
              (i % 5 == 0) ? 16'h0000 : (i % 5 == 1) ? 16'hFFFF : 16'($urandom),
              (i % 7 == 0) ? 16'h0000 : (i % 7 == 1) ? 16'hFFFF : 16'($urandom));
      end
      drain();

      // Backpressure pattern 1,0,0,1 with incrementing sideband
      rdy_mode = 1;
      rdy_phase = 0;
      for (int i = 0; i < 10; i++)
         send(2'd1, UW'(i), PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom),
              16'($urandom), 16'($urandom));
      drain();

      // Mid-stream reset with three samples held in flight
      rdy_mode = 2;
      for (int i = 0; i < 3; i++)
         send(2'd0, UW'(i + 8), PW'($urandom), '0, '0, '0, '0, '0);
      @(negedge aclk);
      s_valid = 1'b0;
      repeat (2) @(negedge aclk);
      #4;
      resetn = 1'b0;
      #1;
      check("async_rst_m_valid", PW'(m_valid), PW'(0));
      sb.delete();
      repeat (2) @(negedge aclk);
      resetn = 1'b1;
      rdy_mode = 0;
      repeat (12) @(negedge aclk);
      check("post_rst_idle", PW'(m_valid), PW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
